aes_job_scheduler: RTL and testbench
====================================

Name: aes_job_scheduler

Overview:
Shares one aes_encrypt core between NUM_REQ requesters using round-robin arbitration. Each granted job's plaintext, key and key_len are latched, then the core is started with a one-cycle nonzero key_len and the scheduler waits for core ready. The ciphertext is returned to the owning requester, and the core is cleared with core_reset between jobs. Sits between the host-side request ports and the aes_encrypt instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in BUSY before the job is aborted
CNT_W, 7, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held until matching done
req_plaintext  in  128*NUM_REQ  requester i in bits [128*i+127:128*i]
req_key  in  256*NUM_REQ  requester i in bits [256*i+255:256*i]
req_key_len  in  3*NUM_REQ  one-hot: 001=128b, 010=192b, 100=256b
done  out  NUM_REQ  one-cycle one-hot completion pulse
err  out  1  valid with done; 1 = rejected key_len or timeout
resp_ciphertext  out  128  valid while done!=0; 0 on error
busy  out  1  high in every state except IDLE
core_reset  out  1  reset to the core
core_plaintext  out  128  latched job plaintext
core_key  out  256  latched job key
core_key_len  out  3  nonzero only in ISSUE; 0 otherwise
core_ciphertext  in  128  core result
core_ready  in  1  core completion level, cleared by core_reset

Behaviour:
- Reset values: done=0, err=0, resp_ciphertext=0, busy=0, core_reset=1, core_plaintext=0, core_key=0, core_key_len=0, rr pointer=0, state=IDLE. core_reset stays 1 for the first cycle after reset deasserts, then drops to 0.
- Reset mid-job: the job is dropped and no done pulse is issued. Requesters re-request.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any req is set, grant the lowest index at or above rr_ptr, wrapping around. Latch that requester's data and index g.
  - If the latched key_len is not exactly one-hot, go to DONE with err=1 and do not start the core.
  - Otherwise go to ISSUE.
- ISSUE: drive core_key_len to the latched value for exactly 1 cycle, clear the counter, go to BUSY.
- BUSY:
  - Increment the counter each cycle.
  - If core_ready=1, capture core_ciphertext and go to DONE with err=0.
  - Else, if the counter reaches TIMEOUT-1, go to DONE with err=1.
  - core_ready has priority over timeout in the same cycle.
- DONE (1 cycle):
  - done[g]=1; resp_ciphertext = captured value (or 0 on error); err as set.
  - core_reset=1 this cycle.
  - rr_ptr = (g+1) mod NUM_REQ.
  - Next state is IDLE.
- Latency: grant at cycle T, ISSUE at T+1, BUSY from T+2, done at (first core_ready cycle)+1. A rejected job completes with done at T+1.
- Throughput: a new grant is possible the cycle after DONE. Only one job is in flight at a time.
- Requester rules:
  - A req dropped before its done is ignored if it has not yet been granted. After grant the job completes anyway.
  - req may stay high after done; that counts as a new request and is arbitrated fairly.
- Outputs are registered. done and err never assert outside DONE.

Decomposition:
- Shared package aes_pkg holds:
  - KEYLEN_128=3'b001, KEYLEN_192=3'b010, KEYLEN_256=3'b100
  - state encoding constants
  - block width 128 and key width 256
- Sub-module rr_arbiter (NUM_REQ param): inputs req and ptr; outputs one-hot grant and index. Purely combinational, reused elsewhere.

Test Plan:
- Single job: req[0]=1, key_len=100, core model ready 15 cycles after start -> exactly one ISSUE cycle with core_key_len=100, done=0001 with CT equal to the model output, err=0, core_reset pulsed in the DONE cycle.
- Fairness: req=1111 held continuously -> done order 0,1,2,3,0,1, with no requester served twice before the others.
- Rejection: req[2] with key_len=011 -> done=0100 and err=1 one cycle after grant, core_key_len never nonzero, resp_ciphertext=0.
- Timeout: core model never asserts ready, TIMEOUT=64 -> done with err=1 after 64 BUSY cycles, core_reset=1, next job then served normally.
- Ready at timeout edge: core_ready arrives in the same cycle the counter hits 63 -> err=0 and CT captured.
- Reset mid-BUSY: reset asserted during a job -> no done pulse, core_reset=1 in the reset cycle and the following cycle, busy=0, then rr_ptr=0 so req=1010 grants requester 1 first.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES job scheduler: data widths, key-length codes
// and the scheduler state encoding.
package aes_pkg;

  localparam int unsigned BlockW = 128;
  localparam int unsigned KeyW   = 256;

  localparam logic [2:0] KEYLEN_128 = 3'b001;
  localparam logic [2:0] KEYLEN_192 = 3'b010;
  localparam logic [2:0] KEYLEN_256 = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  // Only the three one-hot codes are legal; anything else is rejected.
  function automatic logic keylen_valid(logic [2:0] kl);
    return (kl == KEYLEN_128) || (kl == KEYLEN_192) || (kl == KEYLEN_256);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above ptr, wrapping around. Grant is one-hot; all-zero when nothing requests.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one aes_encrypt core between NUM_REQ requesters: round-robin grant,
// one-cycle start pulse, wait for ready or timeout, return result, reset core.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BlockW*NUM_REQ-1:0] req_plaintext,
  input  logic [KeyW*NUM_REQ-1:0]   req_key,
  input  logic [3*NUM_REQ-1:0]      req_key_len,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [BlockW-1:0]         resp_ciphertext,
  output logic                      busy,
  output logic                      core_reset,
  output logic [BlockW-1:0]         core_plaintext,
  output logic [KeyW-1:0]           core_key,
  output logic [2:0]                core_key_len,
  input  logic [BlockW-1:0]         core_ciphertext,
  input  logic                      core_ready
);

  localparam int unsigned      IdxW    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_REQ - 1);

  sched_state_e        state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic [NUM_REQ-1:0]  owner_oh_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IdxW-1:0]     arb_idx;
  logic [BlockW-1:0]   sel_pt;
  logic [KeyW-1:0]     sel_key;
  logic [2:0]          sel_kl;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign sel_pt  = req_plaintext[arb_idx * BlockW +: BlockW];
  assign sel_key = req_key[arb_idx * KeyW +: KeyW];
  assign sel_kl  = req_key_len[arb_idx * 3 +: 3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      owner_oh_q      <= '0;
      cnt_q           <= '0;
      done            <= '0;
      err             <= 1'b0;
      resp_ciphertext <= '0;
      busy            <= 1'b0;
      core_reset      <= 1'b1;
      core_plaintext  <= '0;
      core_key        <= '0;
      core_key_len    <= '0;
    end else begin
      // Pulse-type outputs default low; the DONE/ISSUE entries raise them.
      done            <= '0;
      err             <= 1'b0;
      resp_ciphertext <= '0;
      core_reset      <= 1'b0;
      core_key_len    <= '0;

      unique case (state_q)
        StIdle: begin
          if (|req) begin
            owner_q        <= arb_idx;
            owner_oh_q     <= arb_grant;
            core_plaintext <= sel_pt;
            core_key       <= sel_key;
            busy           <= 1'b1;
            if (keylen_valid(sel_kl)) begin
              core_key_len <= sel_kl;
              state_q      <= StIssue;
            end else begin
              // Bad key length: answer straight away, core is never started.
              done       <= arb_grant;
              err        <= 1'b1;
              core_reset <= 1'b1;
              state_q    <= StDone;
            end
          end
        end

        StIssue: begin
          cnt_q   <= '0;
          state_q <= StBusy;
        end

        StBusy: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_ready) begin
            done            <= owner_oh_q;
            resp_ciphertext <= core_ciphertext;
            core_reset      <= 1'b1;
            state_q         <= StDone;
          end else if (cnt_q == CntLast) begin
            done       <= owner_oh_q;
            err        <= 1'b1;
            core_reset <= 1'b1;
            state_q    <= StDone;
          end
        end

        StDone: begin
          rr_ptr_q <= (owner_q == IdxLast) ? '0 : owner_q + 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Randomised self-checking bench for aes_job_scheduler with a behavioural core
// model and a round-robin reference model.
module tb_aes_job_scheduler;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [128*N-1:0] req_plaintext;
  logic [256*N-1:0] req_key;
  logic [3*N-1:0]   req_key_len;
  logic [N-1:0]     done;
  logic             err;
  logic [127:0]     resp_ciphertext;
  logic             busy;
  logic             core_reset;
  logic [127:0]     core_plaintext;
  logic [255:0]     core_key;
  logic [2:0]       core_key_len;
  logic [127:0]     core_ciphertext;
  logic             core_ready;

  aes_job_scheduler #(
    .NUM_REQ (N),
    .TIMEOUT (TMO),
    .CNT_W   (7)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_plaintext   (req_plaintext),
    .req_key         (req_key),
    .req_key_len     (req_key_len),
    .done            (done),
    .err             (err),
    .resp_ciphertext (resp_ciphertext),
    .busy            (busy),
    .core_reset      (core_reset),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_key_len    (core_key_len),
    .core_ciphertext (core_ciphertext),
    .core_ready      (core_ready)
  );

  always #5 clk = ~clk;

  // Reference data per requester.
  logic [127:0] m_pt  [N];
  logic [255:0] m_key [N];
  logic [2:0]   m_kl  [N];
  int           exp_ptr;

  int n_cmp, n_bad;
  int n_issue, n_done, n_stray;
  logic [2:0] last_kl;

  // Core model state.
  bit           core_run;
  bit           core_never;
  int           core_rem;
  int           core_delay;
  logic [127:0] cm_pt;
  logic [255:0] cm_key;
  logic [2:0]   cm_kl;

  function automatic logic [127:0] core_fn(logic [127:0] pt, logic [255:0] k, logic [2:0] kl);
    logic [127:0] hi;
    hi = k[255:128];
    return pt ^ k[127:0] ^ {hi[126:0], hi[127]} ^ {125'd0, kl};
  endfunction

  function automatic int rr_pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [2:0] rand_kl();
    logic [2:0] r;
    r = 3'b001 << $urandom_range(0, 2);
    return r;
  endfunction

  task automatic load_req(input int i, input logic [2:0] kl);
    m_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
    m_key[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_kl[i]  = kl;
    req_plaintext[128*i +: 128] = m_pt[i];
    req_key[256*i +: 256]       = m_key[i];
    req_key_len[3*i +: 3]       = kl;
  endtask

  // One clock: sample after the edge, update monitors and the core model.
  task automatic step();
    @(posedge clk);
    #1;
    if (core_key_len != 3'b000) begin
      n_issue++;
      last_kl = core_key_len;
    end
    if (done != '0) n_done++;
    if (err && done == '0) n_stray++;
    if (done != '0 && !$onehot(done)) n_stray++;
    if (core_reset) begin
      core_ready = 1'b0;
      core_run   = 1'b0;
    end else if (core_run) begin
      core_rem--;
      if (core_rem == 0) begin
        core_ready      = 1'b1;
        core_ciphertext = core_fn(cm_pt, cm_key, cm_kl);
        core_run        = 1'b0;
      end
    end
    if (core_key_len != 3'b000 && !core_reset) begin
      core_run   = 1'b1;
      core_rem   = core_never ? 1000000 : core_delay;
      cm_pt      = core_plaintext;
      cm_key     = core_key;
      cm_kl      = core_key_len;
      core_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (done != '0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset   = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (resp_ciphertext !== '0) begin n_bad++; $display("FAIL reset_resp: got %h want 0", resp_ciphertext); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (core_plaintext !== '0) begin n_bad++; $display("FAIL reset_core_pt: got %h want 0", core_plaintext); end
    n_cmp++; if (core_key !== '0) begin n_bad++; $display("FAIL reset_core_key: got %h want 0", core_key); end
    n_cmp++; if (core_key_len !== '0) begin n_bad++; $display("FAIL reset_core_kl: got %b want 0", core_key_len); end
    reset   = 1'b0;
    exp_ptr = 0;
    step();
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL reset_release: got %b want 0", core_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int lat, issues0;
    logic [127:0] want;
    load_req(0, 3'b100);
    core_delay = 15;
    issues0    = n_issue;
    want       = core_fn(m_pt[0], m_key[0], m_kl[0]);
    req        = 4'b0001;
    wait_done(40, lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL single_latency: got %0d want 17", lat); end
    n_cmp++; if (done !== 4'b0001) begin n_bad++; $display("FAIL single_done: got %b want 0001", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
    n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL single_ct: got %h want %h", resp_ciphertext, want); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL single_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (n_issue - issues0 !== 1) begin n_bad++; $display("FAIL single_issue_cycles: got %0d want 1", n_issue - issues0); end
    n_cmp++; if (last_kl !== 3'b100) begin n_bad++; $display("FAIL single_issue_kl: got %b want 100", last_kl); end
    n_cmp++; if (core_plaintext !== m_pt[0]) begin n_bad++; $display("FAIL single_core_pt: got %h want %h", core_plaintext, m_pt[0]); end
    req     = '0;
    exp_ptr = 1;
    step();
    n_cmp++; if (done !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL single_after_done: got %b/%b want 0/0", done, err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_after_busy: got %b want 0", busy); end
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL single_after_core_reset: got %b want 0", core_reset); end
  endtask

  task automatic test_reject();
    logic [2:0] bad [6];
    int lat, i, issues0;
    logic [N-1:0] want_done;
    bad = '{3'b011, 3'b000, 3'b101, 3'b110, 3'b111, 3'b011};
    for (int t = 0; t < 6; t++) begin
      i = (t == 0) ? 2 : int'($urandom_range(0, N - 1));
      load_req(i, bad[t]);
      issues0   = n_issue;
      want_done = '0;
      want_done[i] = 1'b1;
      req = want_done;
      wait_done(5, lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL reject_latency[%0d]: got %0d want 1", t, lat); end
      n_cmp++; if (done !== want_done) begin n_bad++; $display("FAIL reject_done[%0d]: got %b want %b", t, done, want_done); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL reject_err[%0d]: got %b want 1", t, err); end
      n_cmp++; if (resp_ciphertext !== '0) begin n_bad++; $display("FAIL reject_ct[%0d]: got %h want 0", t, resp_ciphertext); end
      n_cmp++; if (n_issue !== issues0) begin n_bad++; $display("FAIL reject_core_started[%0d]: got %0d want %0d", t, n_issue, issues0); end
      req     = '0;
      exp_ptr = (i + 1) % N;
      step();
    end
  endtask

  task automatic test_timeout();
    int lat, d;
    logic [127:0] want;
    load_req(1, rand_kl());
    core_never = 1'b1;
    req = 4'b0010;
    wait_done(TMO + 20, lat);
    n_cmp++; if (lat !== TMO + 2) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", lat, TMO + 2); end
    n_cmp++; if (done !== 4'b0010) begin n_bad++; $display("FAIL timeout_done: got %b want 0010", done); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    n_cmp++; if (resp_ciphertext !== '0) begin n_bad++; $display("FAIL timeout_ct: got %h want 0", resp_ciphertext); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL timeout_core_reset: got %b want 1", core_reset); end
    req        = '0;
    core_never = 1'b0;
    exp_ptr    = 2;
    step();
    d = int'($urandom_range(1, 10));
    core_delay = d;
    load_req(3, rand_kl());
    want = core_fn(m_pt[3], m_key[3], m_kl[3]);
    req  = 4'b1000;
    wait_done(40, lat);
    n_cmp++; if (lat !== d + 2) begin n_bad++; $display("FAIL post_timeout_latency: got %0d want %0d", lat, d + 2); end
    n_cmp++; if (done !== 4'b1000 || err !== 1'b0) begin n_bad++; $display("FAIL post_timeout_done: got %b/%b want 1000/0", done, err); end
    n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL post_timeout_ct: got %h want %h", resp_ciphertext, want); end
    req     = '0;
    exp_ptr = 0;
    step();
  endtask

  // Ready exactly on the last counted BUSY cycle wins; one cycle later loses.
  task automatic test_ready_edge();
    int lat, i;
    logic [127:0] want;
    logic [N-1:0] want_done;
    for (int t = 0; t < 2; t++) begin
      i = int'($urandom_range(0, N - 1));
      load_req(i, rand_kl());
      want       = (t == 0) ? core_fn(m_pt[i], m_key[i], m_kl[i]) : '0;
      core_delay = TMO + t;
      want_done  = '0;
      want_done[i] = 1'b1;
      req = want_done;
      wait_done(TMO + 20, lat);
      n_cmp++; if (lat !== TMO + 2) begin n_bad++; $display("FAIL edge_latency[%0d]: got %0d want %0d", t, lat, TMO + 2); end
      n_cmp++; if (done !== want_done) begin n_bad++; $display("FAIL edge_done[%0d]: got %b want %b", t, done, want_done); end
      n_cmp++; if (err !== 1'(t)) begin n_bad++; $display("FAIL edge_err[%0d]: got %b want %0d", t, err, t); end
      n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL edge_ct[%0d]: got %h want %h", t, resp_ciphertext, want); end
      req     = '0;
      exp_ptr = (i + 1) % N;
      step();
    end
  endtask

  task automatic test_fairness();
    int lat, g, d, want_lat;
    logic [127:0] want;
    logic [N-1:0] want_done;
    do_reset();
    for (int i = 0; i < N; i++) load_req(i, rand_kl());
    req = '1;
    for (int j = 0; j < 6; j++) begin
      g = rr_pick(req, exp_ptr);
      d = int'($urandom_range(1, 20));
      core_delay = d;
      want = core_fn(m_pt[g], m_key[g], m_kl[g]);
      want_lat = (j == 0) ? d + 2 : d + 3;
      want_done = '0;
      want_done[g] = 1'b1;
      wait_done(60, lat);
      n_cmp++; if (lat !== want_lat) begin n_bad++; $display("FAIL fair_latency[%0d]: got %0d want %0d", j, lat, want_lat); end
      n_cmp++; if (done !== want_done) begin n_bad++; $display("FAIL fair_order[%0d]: got %b want %b", j, done, want_done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fair_err[%0d]: got %b want 0", j, err); end
      n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL fair_ct[%0d]: got %h want %h", j, resp_ciphertext, want); end
      exp_ptr = (g + 1) % N;
      load_req(g, rand_kl());
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    int lat, d, done0;
    logic [127:0] want;
    load_req(0, rand_kl());
    core_delay = 30;
    req = 4'b0001;
    repeat (10) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    done0 = n_done;
    reset = 1'b1;
    step();
    n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL mid_reset_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL mid_reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (core_key_len !== '0) begin n_bad++; $display("FAIL mid_reset_kl: got %b want 0", core_key_len); end
    reset   = 1'b0;
    exp_ptr = 0;
    load_req(1, rand_kl());
    load_req(3, rand_kl());
    req = 4'b1010;
    d = int'($urandom_range(1, 12));
    core_delay = d;
    want = core_fn(m_pt[1], m_key[1], m_kl[1]);
    wait_done(40, lat);
    n_cmp++; if (lat !== d + 2) begin n_bad++; $display("FAIL mid_first_latency: got %0d want %0d", lat, d + 2); end
    n_cmp++; if (done !== 4'b0010) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0010", done); end
    n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL mid_first_ct: got %h want %h", resp_ciphertext, want); end
    n_cmp++; if (n_done !== done0 + 1) begin n_bad++; $display("FAIL mid_dropped_job: got %0d dones want %0d", n_done - done0, 1); end
    req = 4'b1000;
    d = int'($urandom_range(1, 12));
    core_delay = d;
    want = core_fn(m_pt[3], m_key[3], m_kl[3]);
    wait_done(40, lat);
    n_cmp++; if (lat !== d + 3) begin n_bad++; $display("FAIL mid_second_latency: got %0d want %0d", lat, d + 3); end
    n_cmp++; if (done !== 4'b1000 || err !== 1'b0) begin n_bad++; $display("FAIL mid_second_done: got %b/%b want 1000/0", done, err); end
    n_cmp++; if (resp_ciphertext !== want) begin n_bad++; $display("FAIL mid_second_ct: got %h want %h", resp_ciphertext, want); end
    req = '0;
    step();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_issue = 0; n_done = 0; n_stray = 0;
    last_kl = '0;
    reset = 1'b1;
    req = '0;
    req_plaintext = '0;
    req_key = '0;
    req_key_len = '0;
    core_ready = 1'b0;
    core_ciphertext = '0;
    core_run = 1'b0;
    core_never = 1'b0;
    core_rem = 0;
    core_delay = 1;
    cm_pt = '0; cm_key = '0; cm_kl = '0;
    exp_ptr = 0;

    test_reset();
    test_single();
    test_reject();
    test_timeout();
    test_ready_edge();
    test_fairness();
    test_reset_mid();

    n_cmp++; if (n_stray !== 0) begin n_bad++; $display("FAIL stray_done_err: got %0d want 0", n_stray); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
